fft_bfly_pipe: RTL

- Pipelined radix-2 DIT butterfly for the tuner FFT datapath; successor to the combinational Q1.15 complex multiplier.
- Computes Y0 = A + W·B and Y1 = A − W·B, with optional per-transaction scale-by-½.
- Carries a sideband tag so the FFT address sequencer can track results.
- Valid/ready on both sides; sits between the sample/twiddle memories and the FFT result write-back.

---
 rtl/fft_bfly_pipe.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: pipelined radix-2 DIT butterfly for the tuner FFT datapath.
//
// Computes y0 = A + W*B and y1 = A - W*B on signed Q1.(W-1) complex data, with an
// optional per-transaction divide-by-2. Four register stages (S1..S4), each with its own
// valid bit; bubbles collapse so up to four transactions are held under backpressure.
//
// Build option:
//   FFT_BFLY_SAT_EN - when defined, the final reduction to W bits saturates instead of
//                     wrapping. Latency and handshake are unchanged.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; discards everything in flight
//   in_valid   input transaction present
//   in_ready   block accepts the input this cycle
//   a_in       operand A, {re, im}
//   b_in       operand B, {re, im}
//   w_in       twiddle,   {re, im}
//   scale_in   1 = divide both outputs by 2
//   tag_in     sideband tag, passed through unchanged
//   out_valid  result present
//   out_ready  downstream accepts the result
//   y0_out     A + W*B, {re, im}
//   y1_out     A - W*B, {re, im}
//   tag_out    tag of the current result
module fft_bfly_pipe #(
    parameter int unsigned W     = 16,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   a_in,
    input  logic [2*W-1:0]   b_in,
    input  logic [2*W-1:0]   w_in,
    input  logic             scale_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   y0_out,
    output logic [2*W-1:0]   y1_out,
    output logic [TAG_W-1:0] tag_out
);

    // ------------------------------------------------------------------------------------
    // Flow control: a stage may load when it is empty or its content moves on this cycle.
    // ------------------------------------------------------------------------------------
    logic s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
    logic s1_ok, s2_ok, s3_ok, s4_ok;

    assign s4_ok = !s4_valid_q || out_ready;
    assign s3_ok = !s3_valid_q || s4_ok;
    assign s2_ok = !s2_valid_q || s3_ok;
    assign s1_ok = !s1_valid_q || s2_ok;

    assign in_ready  = s1_ok;
    assign out_valid = s4_valid_q;

    // ------------------------------------------------------------------------------------
    // S1: operand registers
    // ------------------------------------------------------------------------------------
    logic [2*W-1:0]   s1_a_q, s1_b_q, s1_w_q;
    logic             s1_scale_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_w_q     <= '0;
            s1_scale_q <= 1'b0;
            s1_tag_q   <= '0;
        end else if (s1_ok) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q     <= a_in;
                s1_b_q     <= b_in;
                s1_w_q     <= w_in;
                s1_scale_q <= scale_in;
                s1_tag_q   <= tag_in;
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // S2: four partial products. Operands are sign-extended to 2W so the product width
    // matches the result; the low 2W bits hold the exact signed product.
    // ------------------------------------------------------------------------------------
    logic signed [2*W-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
    logic signed [2*W-1:0] rr_d, ii_d, ri_d, ir_d;

    assign b_re_x = {{W{s1_b_q[2*W-1]}}, s1_b_q[2*W-1:W]};
    assign b_im_x = {{W{s1_b_q[W-1]}},   s1_b_q[W-1:0]};
    assign w_re_x = {{W{s1_w_q[2*W-1]}}, s1_w_q[2*W-1:W]};
    assign w_im_x = {{W{s1_w_q[W-1]}},   s1_w_q[W-1:0]};

    assign rr_d = b_re_x * w_re_x;
    assign ii_d = b_im_x * w_im_x;
    assign ri_d = b_re_x * w_im_x;
    assign ir_d = b_im_x * w_re_x;

    logic [2*W-1:0]   s2_a_q;
    logic             s2_scale_q;
    logic [TAG_W-1:0] s2_tag_q;
    logic [2*W-1:0]   s2_rr_q, s2_ii_q, s2_ri_q, s2_ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_a_q     <= '0;
            s2_scale_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_rr_q    <= '0;
            s2_ii_q    <= '0;
            s2_ri_q    <= '0;
            s2_ir_q    <= '0;
        end else if (s2_ok) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_a_q     <= s1_a_q;
                s2_scale_q <= s1_scale_q;
                s2_tag_q   <= s1_tag_q;
                s2_rr_q    <= rr_d;
                s2_ii_q    <= ii_d;
                s2_ri_q    <= ri_d;
                s2_ir_q    <= ir_d;
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // S3: complex product at 2W+1 bits, then T = P >>> (W-1) kept at W+1 bits. Taking
    // bits [2W-1:W-1] is exactly that shift (floor) followed by the W+1-bit truncation.
    // ------------------------------------------------------------------------------------
    logic [2*W:0] p_re, p_im;
    logic [W:0]   t_re_d, t_im_d;

    assign p_re = {s2_rr_q[2*W-1], s2_rr_q} - {s2_ii_q[2*W-1], s2_ii_q};
    assign p_im = {s2_ri_q[2*W-1], s2_ri_q} + {s2_ir_q[2*W-1], s2_ir_q};

    assign t_re_d = p_re[2*W-1:W-1];
    assign t_im_d = p_im[2*W-1:W-1];

    logic unused_p_bits;
    assign unused_p_bits = ^{p_re[2*W], p_re[W-2:0], p_im[2*W], p_im[W-2:0]};

    logic [2*W-1:0]   s3_a_q;
    logic             s3_scale_q;
    logic [TAG_W-1:0] s3_tag_q;
    logic [W:0]       s3_tre_q, s3_tim_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid_q <= 1'b0;
            s3_a_q     <= '0;
            s3_scale_q <= 1'b0;
            s3_tag_q   <= '0;
            s3_tre_q   <= '0;
            s3_tim_q   <= '0;
        end else if (s3_ok) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_a_q     <= s2_a_q;
                s3_scale_q <= s2_scale_q;
                s3_tag_q   <= s2_tag_q;
                s3_tre_q   <= t_re_d;
                s3_tim_q   <= t_im_d;
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // S4: A +/- T at W+2 bits, optional floor-halving, reduction to W bits.
    // ------------------------------------------------------------------------------------
    logic [W+1:0] a_re_x, a_im_x, t_re_x, t_im_x;
    logic [W+1:0] s0_re, s0_im, s1_re, s1_im;
    logic [W+1:0] h0_re, h0_im, h1_re, h1_im;
    logic [W-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;

    assign a_re_x = {{2{s3_a_q[2*W-1]}}, s3_a_q[2*W-1:W]};
    assign a_im_x = {{2{s3_a_q[W-1]}},   s3_a_q[W-1:0]};
    assign t_re_x = {s3_tre_q[W], s3_tre_q};
    assign t_im_x = {s3_tim_q[W], s3_tim_q};

    assign s0_re = a_re_x + t_re_x;
    assign s0_im = a_im_x + t_im_x;
    assign s1_re = a_re_x - t_re_x;
    assign s1_im = a_im_x - t_im_x;

    // Arithmetic >>> 1 by replicating the sign bit.
    assign h0_re = s3_scale_q ? {s0_re[W+1], s0_re[W+1:1]} : s0_re;
    assign h0_im = s3_scale_q ? {s0_im[W+1], s0_im[W+1:1]} : s0_im;
    assign h1_re = s3_scale_q ? {s1_re[W+1], s1_re[W+1:1]} : s1_re;
    assign h1_im = s3_scale_q ? {s1_im[W+1], s1_im[W+1:1]} : s1_im;

`ifdef FFT_BFLY_SAT_EN
    // The value fits in W bits exactly when the top three bits agree.
    function automatic logic [W-1:0] sat_w(input logic [W+1:0] v);
        if (v[W+1:W-1] == 3'b000 || v[W+1:W-1] == 3'b111) begin
            return v[W-1:0];
        end else if (v[W+1]) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    assign y0_re_d = sat_w(h0_re);
    assign y0_im_d = sat_w(h0_im);
    assign y1_re_d = sat_w(h1_re);
    assign y1_im_d = sat_w(h1_im);
`else
    assign y0_re_d = h0_re[W-1:0];
    assign y0_im_d = h0_im[W-1:0];
    assign y1_re_d = h1_re[W-1:0];
    assign y1_im_d = h1_im[W-1:0];

    logic unused_wrap_bits;
    assign unused_wrap_bits = ^{h0_re[W+1:W], h0_im[W+1:W], h1_re[W+1:W], h1_im[W+1:W]};
`endif

    logic [2*W-1:0]   y0_q, y1_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s4_valid_q <= 1'b0;
            y0_q       <= '0;
            y1_q       <= '0;
            tag_q      <= '0;
        end else if (s4_ok) begin
            s4_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                y0_q  <= {y0_re_d, y0_im_d};
                y1_q  <= {y1_re_d, y1_im_d};
                tag_q <= s3_tag_q;
            end
        end
    end

    assign y0_out  = y0_q;
    assign y1_out  = y1_q;
    assign tag_out = tag_q;

endmodule
